// File: rtl/lcd_scanout.sv
// rtl/lcd_scanout.sv - raster scanout of display RAM into a 1-bit valid/ready pixel stream
// Optional contrast level path: LCD_SCANOUT_CONTRAST_EN.

module lcd_scanout #(
   parameter int FRAME_W = 96,
   parameter int FRAME_H = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic [5:0]  cfg_start_line,
   input  logic        cfg_row_order,
   input  logic        cfg_invert,
   input  logic        cfg_all_on,
   input  logic        cfg_display_en,
`ifdef LCD_SCANOUT_CONTRAST_EN
   input  logic [5:0]  cfg_contrast,
   output logic [7:0]  pix_level,
`endif
   output logic        mem_rd,
   output logic [10:0] mem_addr,
   input  logic [7:0]  mem_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_data,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        busy,
   output logic        frame_done
);

   localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
`ifdef LCD_SCANOUT_CONTRAST_EN
   localparam int EW = 11;
`else
   localparam int EW = 3;
`endif

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    state;
   logic [XW-1:0] x_q;
   logic [5:0]    y_q;
   logic          fetch_en;

   logic [5:0]    start_line_q;
   logic          row_order_q;
   logic          invert_q;
   logic          all_on_q;
   logic          display_en_q;
`ifdef LCD_SCANOUT_CONTRAST_EN
   logic [5:0]    contrast_q;
`endif

   logic          tag_v;
   logic [2:0]    tag_bit;
   logic          tag_sof;
   logic          tag_eol;

   logic [EW-1:0] fifo_q [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic          frame_done_q;

   logic [5:0]    r0;
   logic [5:0]    r;
   logic [2:0]    page;
   logic [10:0]   addr_c;
   logic          last_x;
   logic          last_y;
   logic          pop;
   logic          push;
   logic [2:0]    load;
   logic          credit;
   logic          fetch_go;
   logic [1:0]    count_nx;
   logic          push_pix;
   logic [EW-1:0] push_entry;
   logic [EW-1:0] head;

   // 6-bit add wraps the scanline offset modulo 64; ~r0 is 63-r0 for the flip.
   assign r0     = y_q + start_line_q;
   assign r      = row_order_q ? ~r0 : r0;
   assign page   = r[5:3];
   assign addr_c = {1'b0, page, 7'b0} + {6'b0, page, 2'b0} + {{(11 - XW){1'b0}}, x_q};

   assign last_x = (x_q == XW'(FRAME_W - 1));
   assign last_y = (y_q == 6'(FRAME_H - 1));

   assign pix_valid = (count != 2'd0);
   assign pop       = pix_valid && pix_ready;
   assign push      = tag_v;

   // A read is only launched when its data is guaranteed a FIFO slot even if
   // the consumer stalls from now on.
   assign load     = {1'b0, count} + {2'b0, tag_v} - {2'b0, pop};
   assign credit   = (load < 3'd2);
   assign fetch_go = (state == S_FETCH) && fetch_en && credit;
   assign count_nx = count + {1'b0, push} - {1'b0, pop};

   assign mem_rd   = fetch_go;
   assign mem_addr = (state == S_FETCH) ? addr_c : 11'd0;

   always_comb begin
      push_pix = 1'b0;
      if (display_en_q)
         push_pix = all_on_q | (mem_data[tag_bit] ^ invert_q);
   end

`ifdef LCD_SCANOUT_CONTRAST_EN
   assign push_entry = {(push_pix ? {contrast_q, 2'b11} : 8'h00), push_pix, tag_sof, tag_eol};
`else
   assign push_entry = {push_pix, tag_sof, tag_eol};
`endif

   assign head     = fifo_q[rd_ptr];
   assign pix_data = pix_valid & head[2];
   assign pix_sof  = pix_valid & head[1];
   assign pix_eol  = pix_valid & head[0];
`ifdef LCD_SCANOUT_CONTRAST_EN
   assign pix_level = pix_valid ? head[10:3] : 8'h00;
`endif

   assign busy       = (state != S_IDLE);
   assign frame_done = frame_done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         fetch_en     <= 1'b0;
         start_line_q <= '0;
         row_order_q  <= 1'b0;
         invert_q     <= 1'b0;
         all_on_q     <= 1'b0;
         display_en_q <= 1'b0;
`ifdef LCD_SCANOUT_CONTRAST_EN
         contrast_q   <= '0;
`endif
         tag_v        <= 1'b0;
         tag_bit      <= '0;
         tag_sof      <= 1'b0;
         tag_eol      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         tag_v        <= fetch_go;
         if (fetch_go) begin
            tag_bit <= r[2:0];
            tag_sof <= (x_q == '0) && (y_q == '0);
            tag_eol <= last_x;
         end
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  start_line_q <= cfg_start_line;
                  row_order_q  <= cfg_row_order;
                  invert_q     <= cfg_invert;
                  all_on_q     <= cfg_all_on;
                  display_en_q <= cfg_display_en;
`ifdef LCD_SCANOUT_CONTRAST_EN
                  contrast_q   <= cfg_contrast;
`endif
                  x_q          <= '0;
                  y_q          <= '0;
                  fetch_en     <= 1'b0;
                  state        <= S_FETCH;
               end
            end
            S_FETCH: begin
               // First FETCH cycle is a setup cycle; reads start on the next one.
               fetch_en <= 1'b1;
               if (fetch_go) begin
                  if (last_x) begin
                     x_q <= '0;
                     y_q <= y_q + 6'd1;
                     if (last_y)
                        state <= S_DRAIN;
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if ((count_nx == 2'd0) && !tag_v) begin
                  state        <= S_IDLE;
                  frame_done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= push_entry;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count_nx;
      end
   end

endmodule

// File: doc/lcd_scanout.md
# lcd_scanout

Raster scanout stage downstream of the LCD controller's display RAM. On a frame trigger it walks the visible 96×64 area in raster order and reads one display-RAM byte per pixel through a 1-cycle-latency read port. It applies start-line wrap, row order, invert, all-on and display-enable, and streams 1-bit pixels over a valid/ready interface to the video/framebuffer writer.

## Interface

- `FRAME_W`, default 96: visible columns.
- `FRAME_H`, default 64: visible rows; must be 64.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  single-cycle pulse that starts a frame. Ignored while `busy`=1.
- `cfg_start_line`  in  6  scanline offset. Sampled on the accepted `frame_start`.
- `cfg_row_order`  in  1  1 = vertical flip. Sampled on the accepted `frame_start`.
- `cfg_invert`  in  1  invert pixels. Sampled on the accepted `frame_start`.
- `cfg_all_on`  in  1  force all pixels on. Sampled on the accepted `frame_start`.
- `cfg_display_en`  in  1  0 = blank output. Sampled on the accepted `frame_start`.
- `mem_rd`  out  1  read strobe.
- `mem_addr`  out  11  display-RAM byte address.
- `mem_data`  in  8  read data, valid exactly 1 cycle after `mem_rd`.
- `pix_valid`  out  1  pixel available.
- `pix_ready`  in  1  consumer accepts.
- `pix_data`  out  1  pixel value, 1 = dark.
- `pix_sof`  out  1  qualifies the first pixel of the frame (x=0, y=0).
- `pix_eol`  out  1  qualifies the last pixel of a row (x=FRAME_W-1).
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  1-cycle pulse after the last pixel transfer.

## Operation

- FSM states: IDLE, FETCH, DRAIN.
- IDLE -> FETCH on `frame_start`:
  - latch all `cfg_*` inputs;
  - set x=0, y=0;
  - set `busy`=1.
- FETCH issues one read per pixel, x fastest (0..95), then y (0..63).
  - Address computation:
    - r0 = (y + start_line) mod 64, using a 6-bit wrap-around add.
    - r = row_order ? 63-r0 : r0.
    - page = r[5:3], bit = r[2:0].
    - `mem_addr` = page*132 + x, computed as (page<<7)+(page<<2)+x. Maximum value is 7*132+95 = 1019.
  - Pixel function, with b = mem_data[bit]:
    - !display_en -> 0;
    - else all_on -> 1;
    - else b ^ invert.
  - The bit index and sof/eol flags travel with each read through a 1-stage tag pipeline.
- FETCH -> DRAIN after the read for (95,63) is issued.
- DRAIN -> IDLE when the output buffer is empty and no read is in flight. On that transition:
  - pulse `frame_done`;
  - drop `busy`.
- Output buffer is a 2-entry FIFO carrying {pix, sof, eol}. `pix_*` are driven from its head.
- Read credit: issue a read only when (occupancy + in-flight − pop_this_cycle) < 2. The FIFO never overflows under any `pix_ready` pattern.
- Transfer occurs when `pix_valid` && `pix_ready`.
- Exactly FRAME_W*FRAME_H = 6144 transfers per frame, no duplicates, no drops.
- `frame_start` while `busy` is ignored. The latched config is unaffected.
- `cfg_*` changes mid-frame have no effect until the next accepted `frame_start`.

## Timing

- Reset values: `mem_rd`=0, `mem_addr`=0, `pix_valid`=0, `pix_data`=0, `pix_sof`=0, `pix_eol`=0, `busy`=0, `frame_done`=0, FSM=IDLE, FIFO empty.
- `frame_start` sampled at edge N:
  - `busy`=1 after edge N;
  - first `mem_rd` (addr for x=0,y=0) asserted after edge N+1;
  - `pix_valid` with `pix_sof`=1 asserted after edge N+3.
- Latency from `mem_rd` to `pix_valid` for the same pixel: 2 cycles, when the FIFO is empty.
- With `pix_ready` held at 1: sustained 1 pixel/clock. The last transfer happens 6143 cycles after the first.
- `frame_done` is asserted the cycle after the last transfer. `busy` falls in the same cycle.
- Once `pix_valid` is high, `pix_data`/`pix_sof`/`pix_eol` hold stable until the transfer.
- Asserting `reset_n`=0 mid-frame immediately returns all outputs to their reset values. Any read still in flight is discarded.

## Configuration

- `LCD_SCANOUT_CONTRAST_EN` defined:
  - adds input `cfg_contrast` [5:0], latched with the other `cfg_*` inputs;
  - adds output `pix_level` [7:0], equal to pix ? {contrast, 2'b11} : 8'h00 and carried through the FIFO.
- Undefined: neither port exists and the datapath is 1-bit.

## Test plan

- RAM byte at addr 0 = 8'h01, all else 0; default cfg; `pix_ready`=1 -> first transfer has `pix_sof`=1, `pix_data`=1; exactly 6144 transfers; `frame_done` 1 cycle after the last.
- start_line=1, RAM addr 0 = 8'h02 -> the dark pixel appears at (x=0, y=0); with start_line=63 it appears at (0,2). Checks wrap-around.
- row_order=1, RAM addr 7*132+5 = 8'h80 -> dark pixel at (x=5, y=0) only.
- invert=1 and all_on=0 over an all-zero RAM -> 6144 ones. Then display_en=0 with all_on=1 -> 6144 zeros.
- Random `pix_ready` (50% duty) -> the output stream is identical to the `pix_ready`=1 run; data holds while stalled; the FIFO never overflows.
- `frame_start` re-pulsed mid-frame with start_line=10 -> ignored, frame unchanged. `reset_n` pulsed low at pixel 3000 -> all outputs at reset values, `busy`=0. The next `frame_start` yields a full frame.
